line_cache: RTL and testbench

LINE_CACHE -- requirements
Module: line_cache

---
 rtl/package_project_typedefs.sv | 14 +
 rtl/block_ram.sv | 24 ++
 rtl/cache_tag_array.sv | 33 +++
 rtl/line_cache.sv | 170 +++++++++++++++++
 tb/tb_line_cache.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/package_project_typedefs.sv
`default_nettype none
// package_project_typedefs: shared types for the line cache.
package package_project_typedefs;

  typedef enum logic [1:0] {
    CACHE_IDLE   = 2'd0,
    CACHE_REFILL = 2'd1,
    CACHE_WRITE  = 2'd2
  } CacheLineState;

  localparam int WORD_BYTES = 4;

endpackage
`default_nettype wire

// File: rtl/block_ram.sv
`default_nettype none
// block_ram: simple dual-port RAM, synchronous write, asynchronous read.
module block_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule
`default_nettype wire

// File: rtl/cache_tag_array.sv
`default_nettype none
// cache_tag_array: per-line valid bit and tag; combinational read, valid bits cleared by reset.
module cache_tag_array #(
  parameter int LINES = 64,
  parameter int TAG_W = 22
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [$clog2(LINES)-1:0] index,
  input  logic                     we,
  input  logic [TAG_W-1:0]         wtag,
  output logic                     valid,
  output logic [TAG_W-1:0]         tag
);

  logic [LINES-1:0] valid_bits;
  logic [TAG_W-1:0] tags [LINES];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) valid_bits <= '0;
    else if (we) valid_bits[index] <= 1'b1;
  end

  // Tags are only meaningful under a set valid bit, so they carry no reset.
  always_ff @(posedge clk) begin
    if (we) tags[index] <= wtag;
  end

  assign valid = valid_bits[index];
  assign tag   = tags[index];

endmodule
`default_nettype wire

// File: rtl/line_cache.sv
`default_nettype none
// line_cache: direct-mapped, write-through, no-write-allocate cache with zero-latency read hits.
// Define LINE_CACHE_STATS_EN to add hit_count/miss_count outputs.
module line_cache
  import package_project_typedefs::*;
#(
  parameter int CACHE_SIZE = 1024,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [3:0]  cpu_be,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
`ifdef LINE_CACHE_STATS_EN
  output logic [31:0] hit_count,
  output logic [31:0] miss_count,
`endif
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int LINES  = CACHE_SIZE / (WORD_BYTES * LINE_WORDS);
  localparam int OFF_W  = $clog2(LINE_WORDS) + 2;
  localparam int IDX_W  = $clog2(LINES);
  localparam int TAG_W  = 32 - OFF_W - IDX_W;
  localparam int CNT_W  = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int DEPTH  = LINES * LINE_WORDS;
  localparam int RAM_AW = $clog2(DEPTH);

  CacheLineState     state;
  logic [CNT_W-1:0]  count;
  logic [IDX_W-1:0]  cpu_index;
  logic [TAG_W-1:0]  cpu_tag;
  logic [TAG_W-1:0]  line_tag;
  logic              line_valid;
  logic              hit;
  logic              last_word;
  logic              refill_wr;
  logic              write_upd;
  logic [RAM_AW-1:0] rd_addr;
  logic [RAM_AW-1:0] wr_addr;
  logic [31:0]       line_addr;
  logic [3:0]        lane_we;

  assign cpu_index = cpu_addr[OFF_W +: IDX_W];
  assign cpu_tag   = cpu_addr[31 -: TAG_W];
  assign hit       = line_valid && (line_tag == cpu_tag);
  assign last_word = (count == CNT_W'(LINE_WORDS - 1));
  assign refill_wr = (state == CACHE_REFILL) && mem_ack;
  assign write_upd = (state == CACHE_WRITE) && mem_ack && hit;
  assign line_addr = cpu_addr & ~32'(WORD_BYTES * LINE_WORDS - 1);

  // Index and word-offset fields are adjacent, so the RAM address is a contiguous slice.
  assign rd_addr = RAM_AW'((cpu_addr >> 2) & 32'(DEPTH - 1));
  assign wr_addr = refill_wr ? ((rd_addr & ~RAM_AW'(LINE_WORDS - 1)) | RAM_AW'(count)) : rd_addr;

  cache_tag_array #(
    .LINES (LINES),
    .TAG_W (TAG_W)
  ) u_tags (
    .clk   (clk),
    .reset (reset),
    .index (cpu_index),
    .we    (refill_wr && last_word),
    .wtag  (cpu_tag),
    .valid (line_valid),
    .tag   (line_tag)
  );

  for (genvar b = 0; b < 4; b++) begin : g_lane
    assign lane_we[b] = refill_wr || (write_upd && cpu_be[b]);

    block_ram #(
      .WIDTH (8),
      .DEPTH (DEPTH)
    ) u_ram (
      .clk   (clk),
      .we    (lane_we[b]),
      .waddr (wr_addr),
      .wdata (refill_wr ? mem_rdata[8*b +: 8] : cpu_wdata[8*b +: 8]),
      .raddr (rd_addr),
      .rdata (cpu_rdata[8*b +: 8])
    );
  end

  always_comb begin
    cpu_ready = 1'b0;
    case (state)
      CACHE_IDLE:  cpu_ready = !cpu_req || (!cpu_we && hit);
      CACHE_WRITE: cpu_ready = mem_ack;
      default:     cpu_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= CACHE_IDLE;
      count     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        CACHE_IDLE: begin
          if (cpu_req && cpu_we) begin
            state     <= CACHE_WRITE;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_be    <= cpu_be;
            mem_addr  <= cpu_addr & ~32'd3;
            mem_wdata <= cpu_wdata;
          end else if (cpu_req && !hit) begin
            state    <= CACHE_REFILL;
            count    <= '0;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_be   <= 4'b1111;
            mem_addr <= line_addr;
          end
        end
        CACHE_REFILL: begin
          if (mem_ack) begin
            if (last_word) begin
              state   <= CACHE_IDLE;
              count   <= '0;
              mem_req <= 1'b0;
            end else begin
              count    <= count + CNT_W'(1);
              mem_addr <= mem_addr + 32'd4;
            end
          end
        end
        CACHE_WRITE: begin
          if (mem_ack) begin
            state   <= CACHE_IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
          end
        end
        default: state <= CACHE_IDLE;
      endcase
    end
  end

`ifdef LINE_CACHE_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == CACHE_IDLE && cpu_req && !cpu_we) begin
      if (hit) hit_count  <= hit_count + 32'd1;
      else     miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_line_cache.sv
`default_nettype none
// tb_line_cache: scoreboard bench for line_cache covering refill, hits, write-through,
// eviction and reset abort; a slow memory model acks after two wait cycles.
module tb_line_cache;

  localparam int LW = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [3:0]  cpu_be = 4'h0;
  logic [31:0] cpu_addr = 32'h0;
  logic [31:0] cpu_wdata = 32'h0;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
`ifdef LINE_CACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  typedef struct packed {
    logic [31:0] data;
    logic        hit;
  } rd_exp_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } mem_exp_t;

  rd_exp_t     rd_q[$];
  mem_exp_t    mem_q[$];
  logic [31:0] mem_model [logic [31:0]];

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int req_cyc = 0;
  int last_ack_cyc = -100;
  int ack_total = 0;
  int wait_cnt = 0;

  line_cache #(
    .CACHE_SIZE (1024),
    .LINE_WORDS (LW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_be     (cpu_be),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_ready  (cpu_ready),
`ifdef LINE_CACHE_STATS_EN
    .hit_count  (hit_count),
    .miss_count (miss_count),
`endif
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    return mem_model.exists(a) ? mem_model[a] : 32'h0;
  endfunction

  // Memory model: two idle cycles of mem_req, then a one-cycle ack.
  initial begin : mem_proc
    logic [31:0] w;
    forever begin
      @(posedge clk);
      #1;
      if (mem_ack) begin
        mem_ack  = 1'b0;
        wait_cnt = 0;
      end else if (mem_req) begin
        if (wait_cnt == 2) begin
          mem_ack = 1'b1;
          if (mem_we) begin
            w = model_rd(mem_addr);
            for (int b = 0; b < 4; b++) if (mem_be[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
            mem_model[mem_addr] = w;
          end else begin
            mem_rdata = model_rd(mem_addr);
          end
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT completes a memory or CPU transaction.
  always @(negedge clk) begin : monitor
    mem_exp_t me;
    rd_exp_t  re;
    if (!reset && mem_req && mem_ack) begin
      ack_total++;
      last_ack_cyc = cyc;
      if (mem_q.size() == 0) begin
        checks++;
        $display("FAIL mem_unexpected: got transaction at 0x%08h, expected none", mem_addr);
      end else begin
        me = mem_q.pop_front();
        check("mem_we", 32'(mem_we), 32'(me.we));
        check("mem_addr", mem_addr, me.addr);
        check("mem_be", 32'(mem_be), 32'(me.be));
        if (me.we) check("mem_wdata", mem_wdata, me.wdata);
      end
    end
    if (!reset && cpu_req && cpu_ready) begin
      if (cpu_we) begin
        check("write_ready_with_ack", 32'(mem_ack), 32'd1);
      end else if (rd_q.size() == 0) begin
        checks++;
        $display("FAIL rd_unexpected: got read completion at 0x%08h, expected none", cpu_addr);
      end else begin
        re = rd_q.pop_front();
        check("cpu_rdata", cpu_rdata, re.data);
        if (re.hit) begin
          check("hit_latency", 32'(cyc - req_cyc), 32'd0);
          check("hit_no_mem_req", 32'(mem_req), 32'd0);
        end else begin
          check("replay_after_last_ack", 32'(cyc - last_ack_cyc), 32'd1);
        end
      end
    end
  end

  task automatic wait_ready(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      done = cpu_ready;
    end
    if (!done) begin
      checks++;
      $display("FAIL %s_timeout: got cpu_ready=0 for 200 cycles, expected 1", name);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_refill(input logic [31:0] a, input int words);
    for (int i = 0; i < words; i++)
      mem_q.push_back('{we: 1'b0, addr: (a & ~32'hF) + 32'(4 * i), be: 4'hF, wdata: 32'h0});
  endtask

  task automatic cpu_read(input logic [31:0] a, input logic [31:0] d, input logic exp_hit);
    rd_q.push_back('{data: d, hit: exp_hit});
    if (!exp_hit) push_refill(a, LW);
    cpu_addr = a;
    cpu_we   = 1'b0;
    cpu_be   = 4'h0;
    cpu_req  = 1'b1;
    req_cyc  = cyc;
    wait_ready("read");
    cpu_req = 1'b0;
  endtask

  task automatic cpu_write(input logic [31:0] a, input logic [3:0] lanes, input logic [31:0] d);
    mem_q.push_back('{we: 1'b1, addr: a, be: lanes, wdata: d});
    cpu_addr  = a;
    cpu_we    = 1'b1;
    cpu_be    = lanes;
    cpu_wdata = d;
    cpu_req   = 1'b1;
    wait_ready("write");
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin : stim
    int base;
    bit seen;
    mem_model[32'h040] = 32'h0000_0011;
    mem_model[32'h044] = 32'h0000_0022;
    mem_model[32'h048] = 32'h0000_0033;
    mem_model[32'h04C] = 32'h0000_0044;
    mem_model[32'h440] = 32'h0000_0055;
    mem_model[32'h444] = 32'h0000_0066;
    mem_model[32'h448] = 32'h0000_0077;
    mem_model[32'h44C] = 32'h0000_0088;
    mem_model[32'h1004] = 32'hCAFE_0004;

    repeat (3) @(negedge clk);
    check("reset_cpu_ready", 32'(cpu_ready), 32'd1);
    check("reset_mem_req", 32'(mem_req), 32'd0);
    check("reset_mem_we", 32'(mem_we), 32'd0);
`ifdef LINE_CACHE_STATS_EN
    check("reset_hit_count", hit_count, 32'd0);
    check("reset_miss_count", miss_count, 32'd0);
`endif
    reset = 1'b0;
    @(posedge clk);
    #1;

    cpu_read(32'h040, 32'h0000_0011, 1'b0);
    cpu_read(32'h048, 32'h0000_0033, 1'b1);
    cpu_read(32'h04C, 32'h0000_0044, 1'b1);
    cpu_write(32'h044, 4'b0011, 32'hAAAA_BBBB);
    cpu_read(32'h044, 32'h0000_BBBB, 1'b1);
    cpu_write(32'h048, 4'b0000, 32'hFFFF_FFFF);
    cpu_read(32'h048, 32'h0000_0033, 1'b1);
    cpu_write(32'h1000, 4'b1111, 32'h1234_5678);
    cpu_read(32'h1000, 32'h1234_5678, 1'b0);
    cpu_read(32'h1004, 32'hCAFE_0004, 1'b1);
    cpu_read(32'h440, 32'h0000_0055, 1'b0);
    cpu_read(32'h040, 32'h0000_0011, 1'b0);
    cpu_read(32'h044, 32'h0000_BBBB, 1'b1);
    cpu_read(32'h440, 32'h0000_0055, 1'b0);
`ifdef LINE_CACHE_STATS_EN
    check("hit_count", hit_count, 32'd11);
    check("miss_count", miss_count, 32'd5);
`endif

    // Abort a refill of 0x40 right after its second word is acknowledged.
    push_refill(32'h040, 2);
    base     = ack_total;
    seen     = 1'b0;
    cpu_addr = 32'h040;
    cpu_we   = 1'b0;
    cpu_req  = 1'b1;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      #1;
      seen = (ack_total >= base + 2);
    end
    if (!seen) begin
      checks++;
      $display("FAIL abort_wait_timeout: got %0d acks, expected 2", ack_total - base);
    end
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    reset   = 1'b1;
    #1;
    check("abort_mem_req", 32'(mem_req), 32'd0);
    check("abort_cpu_ready", 32'(cpu_ready), 32'd1);
`ifdef LINE_CACHE_STATS_EN
    check("abort_hit_count", hit_count, 32'd0);
    check("abort_miss_count", miss_count, 32'd0);
`endif
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    cpu_read(32'h040, 32'h0000_0011, 1'b0);
    cpu_read(32'h04C, 32'h0000_0044, 1'b1);

    repeat (3) @(posedge clk);
    check("rd_queue_drained", 32'(rd_q.size()), 32'd0);
    check("mem_queue_drained", 32'(mem_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
